// File: rtl/address_range_sequencer.sv
// Address range sequencer: walks indices start_index..ADDR_COUNT-1 and emits the
// matching raw address (ADDR_BASE + index) mod 2**ADDR_WIDTH over a valid/ready port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no walk; waiting for start (bad start_index pulses error)
// RUN   | beat presented on out_valid; advances on each transfer
module address_range_sequencer #(
  parameter int unsigned ADDR_COUNT = 1,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_index,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] raw_address,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One extra bit so a full-range ADDR_COUNT (2**ADDR_WIDTH) is representable.
  localparam logic [ADDR_WIDTH:0]   COUNT_EXT = (ADDR_WIDTH+1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] BASE_W    = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(ADDR_COUNT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] raw_q, raw_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] index_inc;

  assign index_inc = index_q + 1'b1;

  // Next-state and next-output computation for the walk.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    raw_d   = raw_q;
    last_d  = last_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ({1'b0, start_index} < COUNT_EXT) begin
            state_d = ST_RUN;
            index_d = start_index;
            raw_d   = BASE_W + start_index;
            last_d  = (start_index == LAST_IDX);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A transfer coinciding with abort still counts; done only if it was the last beat.
        if (out_ready && last_q) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end else if (out_ready) begin
          index_d = index_inc;
          raw_d   = raw_q + 1'b1;
          last_d  = (index_inc == LAST_IDX);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any walk without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      raw_q   <= BASE_W;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      raw_q   <= raw_d;
      last_q  <= last_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign out_valid   = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN);
  assign raw_address = raw_q;
  assign index       = index_q;
  assign last        = last_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
